// File: rtl/bytebeat_voice_scheduler.sv
// bytebeat_voice_scheduler
//   Paces the bytebeat generator bank at the audio sample rate. Every CLK_DIV
//   clocks a tick starts a collection window in which each voice is offered
//   exactly one valid/ready handshake; the captured samples are then reduced
//   to one 8-bit PCM value (a single selected voice or the average of all).
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   voice_sel    voice index for single mode (latched on tick)
//   mix_mode     0 = single voice, 1 = average of all voices (latched on tick)
//   pcm_in       voice i sample on bits [8i+7:8i]
//   pcm_vld      per-voice valid from the generators
//   pcm_rdy      per-voice ready toward the generators
//   sample       current PCM sample, held between updates
//   sample_stb   one-cycle pulse when sample updates
//   underrun     sticky: some voice missed its deadline since reset

// Per-voice capture lane: one handshake per collection window.
module bytebeat_voice_lane (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       active,   // scheduler is in COLLECT
    input  logic       clr,      // a new collection window starts next cycle
    input  logic [7:0] din,
    input  logic       vld,
    output logic       rdy,
    output logic       got_nxt,  // got including a handshake this cycle
    output logic [7:0] cap
);
    logic got;

    // Ready comes only from registered state, never from vld.
    assign rdy     = active & ~got;
    assign got_nxt = got | (vld & rdy);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            got <= 1'b0;
            cap <= 8'h80;
        end else begin
            if (vld && rdy) cap <= din;
            got <= clr ? 1'b0 : got_nxt;
        end
    end
endmodule

module bytebeat_voice_scheduler #(
    parameter int NUM_VOICES = 8,    // power of 2, 2..8
    parameter int CLK_DIV    = 1250  // clocks per sample tick, >= 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [2:0]                voice_sel,
    input  logic                      mix_mode,
    input  logic [8*NUM_VOICES-1:0]   pcm_in,
    input  logic [NUM_VOICES-1:0]     pcm_vld,
    output logic [NUM_VOICES-1:0]     pcm_rdy,
    output logic [7:0]                sample,
    output logic                      sample_stb,
    output logic                      underrun
);
    localparam int SHIFT = $clog2(NUM_VOICES);
    localparam int CW    = $clog2(CLK_DIV);

    typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

    state_t                         state, state_n;
    logic [CW-1:0]                  cnt;
    logic                           tick;
    logic                           restart, restart_n;
    logic [2:0]                     sel_q;
    logic                           mode_q;
    logic                           latch, clr, urun_set;
    logic [NUM_VOICES-1:0]          got_nxt;
    logic [NUM_VOICES-1:0][7:0]     cap;
    logic [10:0]                    acc;
    logic [7:0]                     result;

    // Free-running sample-rate divider; runs in every state.
    assign tick = (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= tick ? '0 : cnt + 1'b1;
    end

    genvar g;
    generate
        for (g = 0; g < NUM_VOICES; g++) begin : gen_lane
            bytebeat_voice_lane u_lane (
                .clk     (clk),
                .rst_n   (rst_n),
                .active  (state == COLLECT),
                .clr     (clr),
                .din     (pcm_in[8*g +: 8]),
                .vld     (pcm_vld[g]),
                .rdy     (pcm_rdy[g]),
                .got_nxt (got_nxt[g]),
                .cap     (cap[g])
            );
        end
    endgenerate

    always_comb begin
        state_n   = state;
        restart_n = restart;
        latch     = 1'b0;
        clr       = 1'b0;
        urun_set  = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    latch   = 1'b1;
                    clr     = 1'b1;
                    state_n = COLLECT;
                end
            end
            COLLECT: begin
                if (&got_nxt) begin
                    state_n = EMIT;
                    // Completion on the tick itself: no deadline missed,
                    // but the new window has already begun.
                    if (tick) begin
                        restart_n = 1'b1;
                        latch     = 1'b1;
                    end
                end else if (tick) begin
                    // Deadline missed: emit with stale values for the
                    // missing voices and reopen the window right away.
                    urun_set  = 1'b1;
                    restart_n = 1'b1;
                    latch     = 1'b1;
                    state_n   = EMIT;
                end
            end
            EMIT: begin
                if (restart || tick) begin
                    restart_n = 1'b0;
                    clr       = 1'b1;
                    latch     = tick;
                    state_n   = COLLECT;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Mix: 11 bits hold 8 x 255 without overflow; truncating average.
    always_comb begin
        acc = '0;
        for (int i = 0; i < NUM_VOICES; i++) acc = acc + {3'b000, cap[i]};
        if (mode_q) result = 8'(acc >> SHIFT);
        else        result = cap[sel_q[SHIFT-1:0]];  // sel wraps mod NUM_VOICES
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            restart    <= 1'b0;
            sel_q      <= '0;
            mode_q     <= 1'b0;
            sample     <= 8'h80;
            sample_stb <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_n;
            restart    <= restart_n;
            sample_stb <= (state == EMIT);
            if (state == EMIT) sample <= result;
            if (latch) begin
                sel_q  <= voice_sel;
                mode_q <= mix_mode;
            end
            if (urun_set) underrun <= 1'b1;
        end
    end
endmodule

// File: doc/bytebeat_voice_scheduler.md
# bytebeat_voice_scheduler

Sample-rate scheduler for the bytebeat voice bank. Generates the audio sample tick from the system clock, pulls one sample per tick from each of NUM_VOICES bytebeat generators over their valid/ready output channels, and emits a single 8-bit PCM sample per tick. The output is either one selected voice or the average of all voices. It sits between the generator bank and the PWM audio output stage, replacing free-running `output_s_rdy` tie-offs with paced back-pressure.

## Interface
- NUM_VOICES, 8: number of generator channels; must be a power of 2, range 2..8.
- CLK_DIV, 1250: clocks per sample tick (10 MHz / 8 kHz); minimum 4.
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- voice_sel  in  3  voice index for single mode; sampled on tick cycles only.
- mix_mode  in  1  0 = single voice, 1 = average of all voices; sampled on tick cycles only.
- pcm_in  in  8*NUM_VOICES  voice i sample on bits [8i+7:8i].
- pcm_vld  in  NUM_VOICES  per-voice valid.
- pcm_rdy  out  NUM_VOICES  per-voice ready, toward generator `output_s_rdy`.
- sample  out  8  current PCM sample, held between updates.
- sample_stb  out  1  one-cycle pulse when `sample` updates.
- underrun  out  1  sticky flag: some voice missed a deadline since reset.

## Operation
- Tick counter `cnt`:
  - Counts 0..CLK_DIV-1 and wraps.
  - `tick` is combinational: `cnt == CLK_DIV-1`.
  - Counts freely in every state.
- Reset values:
  - `cnt` = 0, state IDLE.
  - `got` = 0.
  - All captured voice registers = 8'h80.
  - `sample` = 8'h80, `sample_stb` = 0, `pcm_rdy` = 0, `underrun` = 0.
  - `restart` = 0; latched `sel` = 0, latched `mode` = 0.
- FSM states: IDLE, COLLECT, EMIT.
- IDLE:
  - `pcm_rdy` = 0.
  - On `tick`: latch `voice_sel` and `mix_mode`, clear `got`, go to COLLECT.
- COLLECT:
  - `pcm_rdy[i] = !got[i]`, combinational from registered state.
  - On `pcm_vld[i] & pcm_rdy[i]`: capture `pcm_in` slice i and set `got[i]`. Any number of voices may handshake in the same cycle.
  - When all `got` bits are set (including bits set this cycle): go to EMIT.
  - On `tick` before collection completes:
    - Capture any handshakes in this cycle.
    - Uncaptured voices keep their previous value.
    - Set `underrun` = 1, set `restart` = 1, go to EMIT.
    - The forced tick also latches new `voice_sel` / `mix_mode`.
  - If completion and `tick` occur in the same cycle: no underrun; set `restart` = 1.
- EMIT:
  - `pcm_rdy` = 0.
  - Compute the result from captured values:
    - mode 0: `captured[sel]`. If `sel >= NUM_VOICES`, use `captured[sel mod NUM_VOICES]`.
    - mode 1: sum of all captured values in an 11-bit unsigned accumulator, shifted right by log2(NUM_VOICES), truncating (no rounding).
  - Register the result into `sample` and pulse `sample_stb`; both visible the cycle after EMIT.
  - Next state: if `restart` or `tick` this cycle, clear `restart` and `got` and go to COLLECT (a tick in EMIT also latches sel/mode); otherwise go to IDLE.
- `underrun` clears only on reset.
- Reset asserted mid-operation: immediate return to reset values. Partially captured data is discarded, and no `sample_stb` is issued.

## Timing
- The tick cycle is T.
- COLLECT occupies T+1 onward. With all `pcm_vld` high, all voices handshake in T+1.
- EMIT occurs at T+2.
- `sample` and `sample_stb` appear at T+3.
- Minimum tick-to-strobe latency: 3 cycles.
- Exactly one `sample_stb` per tick in steady state, including underrun periods.
- `pcm_rdy` never asserts in IDLE or EMIT. Each voice sees at most one handshake per tick period.
- `pcm_rdy` does not depend combinationally on `pcm_vld`.

## Test plan
- Reset then idle, all `pcm_vld` = 0, CLK_DIV = 8: `sample` = 8'h80, `sample_stb` = 0, `pcm_rdy` = 0 for 7 cycles. At `cnt` = 7, the next cycle shows `pcm_rdy` = 8'hFF.
- Single mode, `voice_sel` = 5, voice i drives 8'h10*i with valid always high: `sample_stb` 3 cycles after each tick with `sample` = 8'h50, period exactly CLK_DIV; each voice sees exactly one handshake per period.
- Mix mode, voices drive 8'hFF, 0, 0, 0, 0, 0, 0, 8'h01: `sample` = (255+1)>>3 = 8'h20. With all voices at 8'hFF: `sample` = 8'hFF (no overflow).
- Staggered valid (voice i valid i cycles after COLLECT entry): `pcm_rdy[i]` drops the cycle after its handshake; EMIT follows voice 7's handshake; `underrun` stays 0.
- Voice 3 valid held low, CLK_DIV = 16: at the next tick, forced EMIT uses the stale 8'h80 for voice 3; `underrun` = 1 and stays set; COLLECT restarts immediately; `sample_stb` cadence stays one per tick.
- `rst_n` pulsed low mid-COLLECT (asynchronously, between edges): all outputs return to reset values immediately; no `sample_stb`; first strobe after release is 3 cycles after the first tick.
